// File: rtl/xmodem_message_rx_if.sv
// Purpose: bundles the serial input, control inputs and packet/buffer outputs of the XMODEM receiver.
// Latency: none, this is wiring only.
// Backpressure: none; the consumer must take every wr_en / msg_valid / eot_seen strobe.
interface xmodem_message_rx_if #(
    parameter int DATA_BYTES = 128
);
    localparam int AW = $clog2(DATA_BYTES);

    logic          rx;
    logic          recv_enable;
    logic [7:0]    expected_blk;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          msg_valid;
    logic          msg_ok;
    logic [2:0]    msg_err;
    logic [7:0]    msg_blk;
    logic          eot_seen;
    logic          busy;

    modport master (
        output rx, recv_enable, expected_blk,
        input  wr_en, wr_addr, wr_data, msg_valid, msg_ok, msg_err, msg_blk, eot_seen, busy
    );

    modport slave (
        input  rx, recv_enable, expected_blk,
        output wr_en, wr_addr, wr_data, msg_valid, msg_ok, msg_err, msg_blk, eot_seen, busy
    );
endinterface

// File: rtl/xmodem_message_rx.sv
// Purpose: 1-bit-per-clock UART deserializer plus XMODEM packet parser (SOH, blk, ~blk, data, checksum).
// Latency: byte events, data writes and packet results appear 1 cycle after the stop-bit sample.
// Backpressure: none; the upper layer must accept each strobe (at most one byte per 10 cycles).
module xmodem_message_rx #(
    parameter int DATA_BYTES     = 128,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic               clk,
    input logic               rst_n,
    xmodem_message_rx_if.slave bus
);
    localparam int AW = $clog2(DATA_BYTES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SOH = 8'h01;
    localparam logic [7:0] EOT = 8'h04;
    localparam logic [2:0] ERR_FRAME   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;

    typedef enum logic [1:0] {D_IDLE, D_DATA, D_STOP} des_t;
    typedef enum logic [2:0] {P_IDLE, P_HUNT, P_GET_BLK, P_GET_BLKN, P_GET_DATA, P_GET_CSUM} pkt_t;

    des_t          r_des;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;

    pkt_t          r_state;
    logic [7:0]    r_blk;
    logic [7:0]    r_blkn;
    logic [7:0]    r_exp_blk;
    logic [7:0]    r_csum;
    logic [AW-1:0] r_idx;
    logic [TW-1:0] r_to_cnt;

    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic          r_msg_valid;
    logic          r_msg_ok;
    logic [2:0]    r_msg_err;
    logic [7:0]    r_msg_blk;
    logic          r_eot;
    logic          r_busy;

    logic          w_start;
    logic          w_idle_hi;
    logic          w_byte_done;
    logic          w_frm_err;
    logic [7:0]    w_byte;
    logic          w_in_pkt;
    logic          w_timeout;
    logic [2:0]    w_chk_err;

    // Byte events are combinational on the stop sample so the parser acts on that same edge.
    assign w_start     = (r_des == D_IDLE) && !bus.rx;
    assign w_idle_hi   = (r_des == D_IDLE) &&  bus.rx;
    assign w_byte_done = (r_des == D_STOP) &&  bus.rx;
    assign w_frm_err   = (r_des == D_STOP) && !bus.rx;
    assign w_byte      = r_shift;
    assign w_in_pkt    = (r_state == P_GET_BLK) || (r_state == P_GET_BLKN) ||
                         (r_state == P_GET_DATA) || (r_state == P_GET_CSUM);
    assign w_timeout   = w_in_pkt && w_idle_hi && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Packet verdict at the checksum byte: header consistency beats block number beats checksum.
    always_comb begin
        w_chk_err = 3'd0;
        if ((r_blk ^ r_blkn) != 8'hFF) begin
            w_chk_err = 3'd1;
        end else if (r_blk != r_exp_blk) begin
            w_chk_err = 3'd2;
        end else if (r_csum != w_byte) begin
            w_chk_err = 3'd3;
        end
    end

    // Deserializer: start bit, 8 data bits MSB first, then one stop sample; next start may follow at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_des     <= D_IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'd0;
        end else begin
            case (r_des)
                D_IDLE: begin
                    if (!bus.rx) begin
                        r_des     <= D_DATA;
                        r_bit_cnt <= 3'd0;
                    end
                end
                D_DATA: begin
                    r_shift   <= {r_shift[6:0], bus.rx};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        r_des <= D_STOP;
                    end
                end
                default: r_des <= D_IDLE;
            endcase
        end
    end

    // Packet FSM with registered strobes, results and the inter-byte idle timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= P_IDLE;
            r_blk       <= 8'd0;
            r_blkn      <= 8'd0;
            r_exp_blk   <= 8'd0;
            r_csum      <= 8'd0;
            r_idx       <= '0;
            r_to_cnt    <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'd0;
            r_msg_valid <= 1'b0;
            r_msg_ok    <= 1'b0;
            r_msg_err   <= 3'd0;
            r_msg_blk   <= 8'd0;
            r_eot       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_wr_en     <= 1'b0;
            r_msg_valid <= 1'b0;
            r_eot       <= 1'b0;

            // Idle count restarts on every start bit and only runs while inside a packet.
            if (!w_in_pkt || w_start) begin
                r_to_cnt <= '0;
            end else if (w_idle_hi && (r_to_cnt != TW'(TIMEOUT_CYCLES))) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end

            if (!bus.recv_enable) begin
                r_state <= P_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    P_IDLE: r_state <= P_HUNT;
                    P_HUNT: begin
                        if (w_byte_done && (w_byte == SOH)) begin
                            r_state <= P_GET_BLK;
                            r_csum  <= 8'd0;
                            r_idx   <= '0;
                            r_busy  <= 1'b1;
                        end else if (w_byte_done && (w_byte == EOT)) begin
                            r_eot <= 1'b1;
                        end
                    end
                    default: begin
                        if (w_frm_err || w_timeout) begin
                            r_state     <= P_HUNT;
                            r_busy      <= 1'b0;
                            r_msg_valid <= 1'b1;
                            r_msg_ok    <= 1'b0;
                            r_msg_err   <= w_frm_err ? ERR_FRAME : ERR_TIMEOUT;
                            r_msg_blk   <= r_blk;
                        end else if (w_byte_done) begin
                            case (r_state)
                                P_GET_BLK: begin
                                    r_blk     <= w_byte;
                                    r_exp_blk <= bus.expected_blk;
                                    r_state   <= P_GET_BLKN;
                                end
                                P_GET_BLKN: begin
                                    r_blkn  <= w_byte;
                                    r_state <= P_GET_DATA;
                                end
                                P_GET_DATA: begin
                                    r_wr_en   <= 1'b1;
                                    r_wr_addr <= r_idx;
                                    r_wr_data <= w_byte;
                                    r_csum    <= r_csum + w_byte;
                                    r_idx     <= r_idx + 1'b1;
                                    if (r_idx == AW'(DATA_BYTES - 1)) begin
                                        r_state <= P_GET_CSUM;
                                    end
                                end
                                default: begin
                                    r_state     <= P_HUNT;
                                    r_busy      <= 1'b0;
                                    r_msg_valid <= 1'b1;
                                    r_msg_ok    <= (w_chk_err == 3'd0);
                                    r_msg_err   <= w_chk_err;
                                    r_msg_blk   <= r_blk;
                                end
                            endcase
                        end
                    end
                endcase
            end
        end
    end

    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.msg_valid = r_msg_valid;
    assign bus.msg_ok    = r_msg_ok;
    assign bus.msg_err   = r_msg_err;
    assign bus.msg_blk   = r_msg_blk;
    assign bus.eot_seen  = r_eot;
    assign bus.busy      = r_busy;
endmodule
